dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arb_pkg.sv | 22 ++
 rtl/rd_tag_pipe.sv | 31 +++
 rtl/dm_arbiter.sv | 101 ++++++++++
 tb/tb_dm_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types for the two-requester data-memory arbiter.
// Holds the requester index encoding and the read-tag record.
package dm_arb_pkg;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_HOST = 1'b1
    } req_idx_e;

    typedef struct packed {
        logic     valid;
        req_idx_e idx;
    } rd_tag_t;

    localparam rd_tag_t TAG_NONE = '{valid: 1'b0, idx: REQ_CORE};

    // Contention winner is whoever was not granted most recently.
    function automatic req_idx_e rr_pick(input req_idx_e last);
        return (last == REQ_CORE) ? REQ_HOST : REQ_CORE;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-tag delay line: a tag pushed in cycle T appears on o_tag in
// cycle T+RD_LAT, aligned with the memory's read data.
module rd_tag_pipe
    import dm_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    rd_tag_t r_stage [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_stage[i] <= TAG_NONE;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[RD_LAT-1];

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter between core (0) and host loader (1) for a
// single-port data memory, with host burst lock and read-tag return.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    req_idx_e r_last;
    logic     r_lock;

    logic     w_g0;
    logic     w_g1;
    logic     w_any;
    logic     w_wr;
    req_idx_e w_idx;
    rd_tag_t  w_push;
    rd_tag_t  w_pop;

    always_comb begin
        w_g0 = 1'b0;
        w_g1 = 1'b0;
        if (rst) begin
            w_g0 = 1'b0;
            w_g1 = 1'b0;
        end else if (r_lock) begin
            w_g1 = req1;
        end else if (req0 && req1) begin
            if (rr_pick(r_last) == REQ_CORE) begin
                w_g0 = 1'b1;
            end else begin
                w_g1 = 1'b1;
            end
        end else begin
            w_g0 = req0;
            w_g1 = req1;
        end
    end

    assign w_any = w_g0 | w_g1;
    assign w_idx = w_g1 ? REQ_HOST : REQ_CORE;
    assign w_wr  = w_g1 ? wr1 : wr0;

    assign gnt0      = w_g0;
    assign gnt1      = w_g1;
    assign mem_addr  = w_g1 ? addr1 : addr0;
    assign mem_wdata = w_g1 ? wdata1 : wdata0;
    assign mem_we    = w_any & w_wr;

    assign w_push = '{valid: w_any & ~w_wr, idx: w_idx};

    // Lock only arms on a host grant and drops on any cycle lock1 is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= REQ_HOST;
            r_lock <= 1'b0;
        end else begin
            if (w_any) begin
                r_last <= w_idx;
            end
            r_lock <= lock1 & (r_lock | w_g1);
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_tag (w_push),
        .o_tag (w_pop)
    );

    assign rvalid0 = ~rst & w_pop.valid & (w_pop.idx == REQ_CORE);
    assign rvalid1 = ~rst & w_pop.valid & (w_pop.idx == REQ_HOST);
    assign rdata   = mem_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with an every-cycle reference model
// and a memory stub returning addr ^ 0x4A after LAT cycles.
module tb_dm_arbiter;

    localparam int LAT = 2;
    localparam int AW  = 16;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, wr0, wr1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .RD_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .wr0       (wr0),
        .wr1       (wr1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .lock1     (lock1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h4A;
    endfunction

    // Memory stub: read data for the command issued LAT cycles ago.
    logic [AW-1:0] hist [LAT];
    always @(posedge clk) begin
        hist[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
    end
    assign mem_rdata = memf(hist[LAT-1]);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: last winner, lock flag, queue of due reads.
    typedef struct {
        int          due;
        int          idx;
        logic [DW-1:0] d;
    } rd_t;

    rd_t  q[$];
    int   m_last = 1;
    bit   m_lock = 0;
    int   cyc    = 0;
    bit   e0, e1, ewr, rv0, rv1;
    logic [DW-1:0] ed;

    always @(negedge clk) begin
        e0 = 0;
        e1 = 0;
        if (!rst) begin
            if (m_lock) e1 = req1;
            else if (req0 && req1) begin
                if (m_last == 1) e0 = 1;
                else e1 = 1;
            end else begin
                e0 = req0;
                e1 = req1;
            end
        end
        ewr = e0 ? wr0 : (e1 ? wr1 : 1'b0);
        chk("m_gnt0", gnt0, e0);
        chk("m_gnt1", gnt1, e1);
        chk("m_we", mem_we, ewr);
        if (e0 || e1) begin
            chk("m_addr", mem_addr, e1 ? addr1 : addr0);
            if (ewr) chk("m_wdata", mem_wdata, e1 ? wdata1 : wdata0);
        end
        rv0 = 0;
        rv1 = 0;
        ed  = '0;
        if (!rst && q.size() > 0 && q[0].due == cyc) begin
            if (q[0].idx == 0) rv0 = 1;
            else rv1 = 1;
            ed = q[0].d;
            void'(q.pop_front());
        end
        chk("m_rvalid0", rvalid0, rv0);
        chk("m_rvalid1", rvalid1, rv1);
        if (rv0 || rv1) chk("m_rdata", rdata, ed);
        if (rst) begin
            m_last = 1;
            m_lock = 0;
            q.delete();
        end else begin
            if (e0 || e1) begin
                m_last = e1 ? 1 : 0;
                if (!ewr)
                    q.push_back('{cyc + LAT, m_last,
                                  memf(e1 ? addr1 : addr0)});
            end
            m_lock = lock1 && (m_lock || e1);
        end
        cyc++;
    end

    task automatic setv(input logic r0, input logic w0,
                        input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, input logic w1,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic lk);
        req0 = r0; wr0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; wr1 = w1; addr1 = a1; wdata1 = d1;
        lock1 = lk;
    endtask

    task automatic idle();
        setv(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        setv(1, 1, 16'h0001, 8'h01, 1, 1, 16'h0002, 8'h02, 1);
        @(negedge clk);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_rv0", rvalid0, 0);
        chk("rst_rv1", rvalid1, 0);
        nxt();
        rst = 1'b0;

        // Single read
        setv(1, 0, 16'h0010, 8'h00, 0, 0, '0, '0, 0);
        @(negedge clk);
        chk("rd_gnt0", gnt0, 1);
        chk("rd_addr", mem_addr, 16'h0010);
        chk("rd_we", mem_we, 0);
        nxt();
        idle();
        @(negedge clk);
        chk("rd_early", rvalid0, 0);
        nxt();
        @(negedge clk);
        chk("rd_rv0", rvalid0, 1);
        chk("rd_data", rdata, 8'h5A);
        nxt();

        // Contention with writes
        do_reset();
        for (int i = 0; i < 4; i++) begin
            setv(1, 1, 16'h0030, 8'h11, 1, 1, 16'h0040, 8'h22, 0);
            @(negedge clk);
            chk("rr_gnt0", gnt0, (i % 2 == 0));
            chk("rr_gnt1", gnt1, (i % 2 == 1));
            chk("rr_we", mem_we, 1);
            chk("rr_addr", mem_addr, (i % 2 == 0) ? 16'h0030 : 16'h0040);
            nxt();
        end

        // Host burst under lock, lock1 low on the last beat
        do_reset();
        setv(1, 1, 16'h0050, 8'h33, 0, 0, '0, '0, 0);
        @(negedge clk);
        chk("bu_pre", gnt0, 1);
        nxt();
        for (int i = 0; i < 4; i++) begin
            setv(1, 1, 16'h0050, 8'h33, 1, 1, 16'h0100 + 16'(i),
                 8'(i), (i < 3));
            @(negedge clk);
            chk("bu_gnt1", gnt1, 1);
            chk("bu_gnt0", gnt0, 0);
            chk("bu_addr", mem_addr, 16'h0100 + 16'(i));
            nxt();
        end
        setv(1, 1, 16'h0050, 8'h33, 1, 1, 16'h0104, 8'h44, 0);
        @(negedge clk);
        chk("bu_after", gnt0, 1);
        nxt();

        // Pipelined reads 0,1,0
        do_reset();
        setv(1, 0, 16'h0020, 8'h00, 0, 0, '0, '0, 0);
        @(negedge clk);
        chk("pr_g0", gnt0, 1);
        nxt();
        setv(0, 0, '0, '0, 1, 0, 16'h0021, 8'h00, 0);
        @(negedge clk);
        chk("pr_g1", gnt1, 1);
        nxt();
        setv(1, 0, 16'h0022, 8'h00, 0, 0, '0, '0, 0);
        @(negedge clk);
        chk("pr_g2", gnt0, 1);
        chk("pr_rv_a", rvalid0, 1);
        chk("pr_d_a", rdata, 8'h6A);
        nxt();
        idle();
        @(negedge clk);
        chk("pr_rv_b", rvalid1, 1);
        chk("pr_d_b", rdata, 8'h6B);
        nxt();
        @(negedge clk);
        chk("pr_rv_c", rvalid0, 1);
        chk("pr_d_c", rdata, 8'h68);
        nxt();
        @(negedge clk);
        chk("pr_end", rvalid0 | rvalid1, 0);
        nxt();

        // Reset mid-read
        do_reset();
        setv(1, 0, 16'h0010, 8'h00, 0, 0, '0, '0, 0);
        @(negedge clk);
        chk("mr_gnt", gnt0, 1);
        nxt();
        rst = 1'b1;
        setv(1, 1, 16'h0011, 8'h55, 1, 1, 16'h0012, 8'h66, 0);
        @(negedge clk);
        chk("mr_g0", gnt0, 0);
        chk("mr_g1", gnt1, 0);
        chk("mr_we", mem_we, 0);
        nxt();
        rst = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mr_norv", rvalid0 | rvalid1, 0);
            nxt();
        end

        // Withdrawn request from host
        do_reset();
        setv(1, 1, 16'h0060, 8'h77, 1, 1, 16'h0061, 8'h88, 0);
        @(negedge clk);
        chk("wd_g0", gnt0, 1);
        chk("wd_g1", gnt1, 0);
        nxt();
        idle();
        @(negedge clk);
        chk("wd_idle", gnt1, 0);
        nxt();
        setv(1, 1, 16'h0062, 8'h99, 1, 1, 16'h0063, 8'hAA, 0);
        @(negedge clk);
        chk("wd_next", gnt1, 1);
        nxt();

        idle();
        nxt();
        nxt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
